// File: rtl/bg_status_uart_tx.sv
// Purpose : UART transmitter shipping 8-bit status/trim words on one pin (start, 8 data LSB first, opt. even parity, stop bits).
// Latency : start bit begins the cycle after acceptance; frame_done pulses the cycle after the last stop-bit cycle.
// Backpress: tx_ready (registered) is high only in IDLE with ena=1; tx_valid without tx_ready is ignored, nothing is queued.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   ena               1 = new frames may be accepted
//   tx_data/tx_valid  word offered by the producer; tx_data is latched on acceptance
//   tx_ready          transmitter accepts a word on this cycle's edge when tx_valid is high
//   tx_out            serial line, idle high, driven from a flop
//   busy              high while a frame is on the line
//   frame_done        one-cycle pulse after a frame completes
module bg_status_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [2:0]      bit_idx_nx;
  logic            stop_cnt;
  logic [7:0]      shreg;
  logic            bit_end;
  logic            accept;
  logic            last_stop;
  logic            tx_out_nx;
  logic            busy_nx;
  logic            done_nx;
  logic            ready_nx;

  assign bit_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign accept    = (state == S_IDLE) && tx_valid && tx_ready;
  // stop_cnt only matters with two stop bits; it marks the second one.
  assign last_stop = bit_end && ((STOP_BITS == 1) || stop_cnt);
  assign bit_idx_nx = ((state == S_DATA) && bit_end) ? bit_idx + 3'd1 : bit_idx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = S_START;
      S_START:  if (bit_end) state_nx = S_DATA;
      S_DATA:   if (bit_end && (bit_idx == 3'd7)) state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nx = S_STOP;
      S_STOP:   if (last_stop) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Output logic: next values of the output flops, decoded from the state
  // being entered so every output lines up with its bit without a comb path.
  always_comb begin
    tx_out_nx = 1'b1;
    case (state_nx)
      S_IDLE:   tx_out_nx = 1'b1;
      S_START:  tx_out_nx = 1'b0;
      S_DATA:   tx_out_nx = shreg[bit_idx_nx];
      S_PARITY: tx_out_nx = ^shreg;
      S_STOP:   tx_out_nx = 1'b1;
      default:  tx_out_nx = 1'b1;
    endcase
    busy_nx  = (state_nx != S_IDLE);
    done_nx  = (state == S_STOP) && (state_nx == S_IDLE);
    // Gating on the next state keeps tx_ready low in the cycle after acceptance.
    ready_nx = (state_nx == S_IDLE) && ena;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      stop_cnt   <= 1'b0;
      shreg      <= 8'h00;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      tx_ready   <= 1'b0;
    end else begin
      baud_cnt   <= ((state == S_IDLE) || bit_end) ? '0 : baud_cnt + 1'b1;
      bit_idx    <= bit_idx_nx;
      stop_cnt   <= ((state == S_STOP) && !last_stop) ? (stop_cnt ^ bit_end) : 1'b0;
      if (accept) begin
        shreg <= tx_data;
      end
      tx_out     <= tx_out_nx;
      busy       <= busy_nx;
      frame_done <= done_nx;
      tx_ready   <= ready_nx;
    end
  end

endmodule

// File: tb/tb_bg_status_uart_tx.sv
// Purpose : self-checking bench for bg_status_uart_tx; three instances cover no parity, parity, two stop bits.
// Latency : expected per-cycle line/busy/done samples are queued at stimulus time and compared against captured samples.
// Backpress: tx_valid is held until tx_ready is seen, with a bounded wait.
module tb_bg_status_uart_tx;

  localparam int CPB = 4;

  typedef struct packed {
    logic s_out;
    logic s_busy;
    logic s_done;
  } samp_t;

  logic       clk;
  logic       rst_n;
  logic       ena        [3];
  logic       tx_valid   [3];
  logic [7:0] tx_data    [3];
  logic       tx_ready   [3];
  logic       tx_out     [3];
  logic       busy       [3];
  logic       frame_done [3];

  int    n_checks = 0;
  int    n_fail   = 0;
  samp_t exp_q[$];
  samp_t obs_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bg_status_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .busy(busy[0]), .frame_done(frame_done[0]));
  bg_status_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .busy(busy[1]), .frame_done(frame_done[1]));
  bg_status_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .ena(ena[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx_out(tx_out[2]), .busy(busy[2]), .frame_done(frame_done[2]));

  // Expected samples for one frame, starting with the first start-bit cycle,
  // followed by the idle cycle carrying frame_done.
  function automatic void push_frame(input logic [7:0] d, input int par, input int stops);
    logic  bits[$];
    samp_t s;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par != 0) bits.push_back(^d);
    for (int i = 0; i < stops; i++) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int c = 0; c < CPB; c++) begin
        s.s_out = bits[i]; s.s_busy = 1'b1; s.s_done = 1'b0;
        exp_q.push_back(s);
      end
    end
    s.s_out = 1'b1; s.s_busy = 1'b0; s.s_done = 1'b1;
    exp_q.push_back(s);
  endfunction

  // Passive monitor: records n cycles of DUT outputs, ends #1 after an edge.
  task automatic capture(input int idx, input int n);
    samp_t s;
    for (int i = 0; i < n; i++) begin
      s.s_out = tx_out[idx]; s.s_busy = busy[idx]; s.s_done = frame_done[idx];
      obs_q.push_back(s);
      @(posedge clk); #1;
    end
  endtask

  // Offers a word and returns in the first start-bit cycle.
  task automatic start_word(input int idx, input logic [7:0] d, input bit hold);
    int t;
    tx_data[idx]  = d;
    tx_valid[idx] = 1'b1;
    t = 0;
    while (tx_ready[idx] !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    n_checks++;
    if (tx_ready[idx] !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_wait dut%0d: tx_ready=%b after %0d cycles, required 1", idx, tx_ready[idx], t);
    end
    @(posedge clk); #1;
    if (!hold) tx_valid[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ena[i] = 1'b1; tx_valid[i] = 1'b0; tx_data[i] = 8'h00;
    end
    #1 rst_n = 1'b0;
    #11;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({tx_out[i], tx_ready[i], busy[i], frame_done[i]} !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_values dut%0d: out/rdy/busy/done=%b required 1000", i,
                 {tx_out[i], tx_ready[i], busy[i], frame_done[i]});
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (tx_ready[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL ready_after_reset dut%0d: tx_ready=%b required 1", i, tx_ready[i]);
      end
    end
  endtask

  task automatic test_basic_a5();
    samp_t e, o;
    int    k;
    push_frame(8'hA5, 0, 1);
    start_word(0, 8'hA5, 1'b0);
    capture(0, 41);
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL frame_a5 cycle %0d: out/busy/done=%b required %b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_parity();
    samp_t      e, o;
    int         k;
    logic [7:0] words[2];
    words[0] = 8'h07;
    words[1] = 8'h03;
    for (int w = 0; w < 2; w++) begin
      push_frame(words[w], 1, 1);
      start_word(1, words[w], 1'b0);
      capture(1, 45);
      k = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL parity_frame %h cycle %0d: out/busy/done=%b required %b", words[w], k, o, e);
        end
        k++;
      end
    end
  endtask

  task automatic test_back_to_back();
    samp_t e, o;
    int    k;
    push_frame(8'h00, 0, 2);
    push_frame(8'hFF, 0, 2);
    start_word(2, 8'h00, 1'b1);
    tx_data[2] = 8'hFF;
    capture(2, 45);
    tx_valid[2] = 1'b0;
    capture(2, 45);
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: out/busy/done=%b required %b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid_frame();
    samp_t e, o;
    int    k;
    push_frame(8'h5A, 0, 1);
    start_word(0, 8'h5A, 1'b0);
    capture(0, 18);
    k = 0;
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL pre_reset_5a cycle %0d: out/busy/done=%b required %b", k, o, e);
      end
      k++;
    end
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx_out[0], tx_ready[0], busy[0], frame_done[0]} !== 4'b1000) begin
      n_fail++;
      $display("FAIL async_reset: out/rdy/busy/done=%b required 1000",
               {tx_out[0], tx_ready[0], busy[0], frame_done[0]});
    end
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({tx_ready[0], busy[0], tx_out[0], frame_done[0]} !== 4'b1010) begin
      n_fail++;
      $display("FAIL post_reset: rdy/busy/out/done=%b required 1010",
               {tx_ready[0], busy[0], tx_out[0], frame_done[0]});
    end
    capture(0, 50);
    k = 0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_checks++;
      if (o !== 3'b100) begin
        n_fail++;
        $display("FAIL post_reset_idle cycle %0d: out/busy/done=%b required 100", k, o);
      end
      k++;
    end
  endtask

  task automatic test_ena_block();
    ena[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tx_data[0]  = 8'h00;
    tx_valid[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      n_checks++;
      if ({tx_ready[0], tx_out[0], busy[0]} !== 3'b010) begin
        n_fail++;
        $display("FAIL ena_block cycle %0d: rdy/out/busy=%b required 010", i,
                 {tx_ready[0], tx_out[0], busy[0]});
      end
      @(posedge clk); #1;
    end
    tx_valid[0] = 1'b0;
    ena[0] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ena_mid_frame();
    samp_t e, o;
    int    k;
    push_frame(8'hC3, 0, 1);
    start_word(0, 8'hC3, 1'b0);
    fork
      capture(0, 41);
      begin
        for (int t = 0; t < 12; t++) begin
          ena[0] = ~ena[0];
          repeat (3) begin @(posedge clk); #1; end
        end
        ena[0] = 1'b0;
      end
    join
    n_checks++;
    if (tx_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ena_low_after_frame: tx_ready=%b required 0", tx_ready[0]);
    end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL ena_mid_frame cycle %0d: out/busy/done=%b required %b", k, o, e);
      end
      k++;
    end
    ena[0] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_data_change();
    samp_t e, o;
    int    k;
    push_frame(8'h3C, 0, 1);
    start_word(0, 8'h3C, 1'b0);
    fork
      capture(0, 41);
      begin
        for (int t = 0; t < 40; t++) begin
          tx_data[0] = 8'($urandom);
          @(posedge clk); #1;
        end
      end
    join
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL data_change_3c cycle %0d: out/busy/done=%b required %b", k, o, e);
      end
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_a5();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_ena_block();
    test_ena_mid_frame();
    test_data_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
